// File: rtl/peripheral_mpi_pkg.sv
// Shared types for the MPI peripheral slice: bridge FSM states, response codes
// and bus geometry helpers.
package peripheral_mpi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_BUS,
    ST_RESP
  } state_e;

  typedef enum logic [1:0] {
    RSP_OK,
    RSP_ERR,
    RSP_TIMEOUT
  } resp_e;

  localparam int unsigned TMR_W = 16;

  // Byte-offset bits that must be zero for a full-word access.
  function automatic int unsigned addr_lsb(input int unsigned dw);
    return (dw == 64) ? 3 : 2;
  endfunction

endpackage

// File: rtl/peripheral_mpi_timeout.sv
// Bus-response watchdog: cleared by load_i, counts enabled cycles and flags
// the cycle on which the TIMEOUT-th enabled cycle is reached.
module peripheral_mpi_timeout
  import peripheral_mpi_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic expired_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == TMR_W'(TIMEOUT - 1));

endmodule

// File: rtl/peripheral_mpi_wb_bridge.sv
// Wishbone (classic or B4 pipelined) slave to generic peripheral bus bridge,
// one transfer at a time, with alignment checks, watchdog and error stats.
module peripheral_mpi_wb_bridge
  import peripheral_mpi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned PIPELINED  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    wb_stall_o,
  output logic [ADDR_WIDTH-1:0]   bus_addr,
  output logic [DATA_WIDTH-1:0]   bus_data_in,
  output logic                    bus_we,
  output logic                    bus_en,
  input  logic [DATA_WIDTH-1:0]   bus_data_out,
  input  logic                    bus_ack,
  input  logic                    bus_err,
  output logic                    timeout_o,
  input  logic                    clr_i,
  output logic [7:0]              err_cnt_o
);

  localparam int unsigned LSB = addr_lsb(DATA_WIDTH);

  state_e                  state_q;
  resp_e                   resp_q;
  logic [ADDR_WIDTH-1:0]   adr_q, bus_addr_q;
  logic [DATA_WIDTH-1:0]   dat_q, bus_data_q, rdata_q, wb_dat_q;
  logic [DATA_WIDTH/8-1:0] sel_q;
  logic                    we_q, bus_we_q, bus_en_q, ack_q, err_q;
  logic                    timeout_q, timeout_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic                    accept, req_bad, tmr_expired, timeout_event, err_event;

  // Classic masters hold stb until they see the response, so the request is
  // not re-sampled during the cycle the ack/err pulse is visible.
  assign accept  = wb_cyc_i && wb_stb_i && ((PIPELINED != 0) || !(ack_q || err_q));
  assign req_bad = (|adr_q[LSB-1:0]) || (sel_q != '1);

  peripheral_mpi_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst),
    .load_i   (state_q == ST_CHECK),
    .en_i     ((state_q == ST_BUS) && bus_en_q),
    .expired_o(tmr_expired)
  );

  assign timeout_event = (state_q == ST_BUS) && bus_en_q && wb_cyc_i &&
                         !bus_err && !bus_ack && tmr_expired;
  assign err_event     = (state_q == ST_RESP) && (resp_q != RSP_OK);

  always_comb begin
    timeout_d = timeout_q | timeout_event;
    err_cnt_d = err_cnt_q;
    if (err_event && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
    if (clr_i) begin
      timeout_d = 1'b0;
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      resp_q     <= RSP_OK;
      adr_q      <= '0;
      dat_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      bus_addr_q <= '0;
      bus_data_q <= '0;
      bus_we_q   <= 1'b0;
      bus_en_q   <= 1'b0;
      rdata_q    <= '0;
      wb_dat_q   <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      wb_dat_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            adr_q   <= wb_adr_i;
            dat_q   <= wb_dat_i;
            sel_q   <= wb_sel_i;
            we_q    <= wb_we_i;
            state_q <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!wb_cyc_i) begin
            state_q <= ST_IDLE;
          end else if (req_bad) begin
            resp_q  <= RSP_ERR;
            state_q <= ST_RESP;
          end else begin
            bus_addr_q <= adr_q;
            bus_data_q <= dat_q;
            bus_we_q   <= we_q;
            state_q    <= ST_BUS;
          end
        end
        ST_BUS: begin
          // First BUS cycle raises bus_en; responses only count once it is seen.
          if (!wb_cyc_i) begin
            bus_en_q <= 1'b0;
            state_q  <= ST_IDLE;
          end else if (!bus_en_q) begin
            bus_en_q <= 1'b1;
          end else if (bus_err) begin
            resp_q   <= RSP_ERR;
            bus_en_q <= 1'b0;
            state_q  <= ST_RESP;
          end else if (bus_ack) begin
            rdata_q  <= bus_data_out;
            resp_q   <= RSP_OK;
            bus_en_q <= 1'b0;
            state_q  <= ST_RESP;
          end else if (tmr_expired) begin
            resp_q   <= RSP_TIMEOUT;
            bus_en_q <= 1'b0;
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: begin
          ack_q <= (resp_q == RSP_OK);
          err_q <= (resp_q != RSP_OK);
          if ((resp_q == RSP_OK) && !we_q) begin
            wb_dat_q <= rdata_q;
          end
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
      timeout_q <= timeout_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign wb_dat_o    = wb_dat_q;
  assign wb_ack_o    = ack_q;
  assign wb_err_o    = err_q;
  assign wb_stall_o  = (PIPELINED != 0) && (state_q != ST_IDLE);
  assign bus_addr    = bus_addr_q;
  assign bus_data_in = bus_data_q;
  assign bus_we      = bus_we_q;
  assign bus_en      = bus_en_q;
  assign timeout_o   = timeout_q;
  assign err_cnt_o   = err_cnt_q;

endmodule
